// File: rtl/num_overlay_ctrl.sv
// num_overlay_ctrl: schedules one seven-segment renderer across DIGITS slots to overlay a BCD fish count.
// Define LEAD_ZERO_BLANK_EN to blank leading zero digits (the LSD is always shown).
module num_overlay_ctrl #(
    parameter int         DIGITS = 7,
    parameter logic [10:0] X0    = 11'd16,
    parameter logic [9:0]  Y0    = 10'd16,
    parameter logic [10:0] PITCH = 11'd20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] value,
    input  logic        value_valid,
    input  logic        frame_start,
    input  logic [10:0] countx,
    input  logic [9:0]  county,
    input  logic        check_in,
    output logic [19:0] mark,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        pix_on,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;
    state_t state, state_nx;
    logic [19:0] pending_val;
    logic pending, start;
    logic [47:0] sr, sr_adj;
    logic [4:0] iter;
    logic [4*DIGITS-1:0] digits;
    logic [DIGITS-1:0] blank;
    logic [10:0] nx, lo, x_nx;
    logic [3:0] mark_nx;
    logic en_nx, slot_en, slot_en_d;
    logic unused_county;
    assign unused_county = ^county;
    assign y = Y0;
    assign busy = (state != IDLE);
    always_comb begin
        state_nx = state;
        start = 1'b0;
        case (state)
            IDLE: if (frame_start && (pending || value_valid)) begin
                start = 1'b1;
                state_nx = CONV;
            end
            CONV: state_nx = (iter == 5'd19) ? LOAD : CONV;
            default: state_nx = IDLE;
        endcase
    end
    // shift-add-3: correct every BCD nibble before the shift doubles it
    always_comb begin
        sr_adj = sr;
        for (int n = 0; n < 7; n++)
            if (sr[20+4*n +: 4] >= 4'd5) sr_adj[20+4*n +: 4] = sr[20+4*n +: 4] + 4'd3;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            pending <= 1'b0;
            pending_val <= '0;
            sr <= '0;
            iter <= '0;
            digits <= '0;
        end else begin
            state <= state_nx;
            pending <= start ? 1'b0 : (pending | value_valid);
            if (value_valid) pending_val <= value;
            if (start) sr <= {28'b0, value_valid ? value : pending_val};
            else if (state == CONV) sr <= {sr_adj[46:0], 1'b0};
            iter <= start ? 5'd0 : (state == CONV) ? iter + 5'd1 : iter;
            if (state == LOAD) digits <= sr[20 +: 4*DIGITS];
        end
    end
`ifdef LEAD_ZERO_BLANK_EN
    logic lead;
    always_comb begin
        lead = 1'b1;
        blank = '0;
        for (int i = 0; i < DIGITS - 1; i++) begin
            lead = lead & (digits[4*(DIGITS-1-i) +: 4] == 4'd0);
            blank[i] = lead;
        end
    end
`else
    assign blank = '0;
`endif
    // look one pixel ahead so x/mark are ready when the renderer samples countx
    always_comb begin
        nx = countx + 11'd1;
        lo = '0;
        x_nx = 11'h7FF;
        mark_nx = '0;
        en_nx = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            lo = X0 + 11'(i) * PITCH;
            if (nx >= lo && nx <= lo + PITCH - 11'd1) begin
                x_nx = lo;
                mark_nx = digits[4*(DIGITS-1-i) +: 4];
                en_nx = ~blank[i];
            end
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x <= '0;
            mark <= '0;
            slot_en <= 1'b0;
            slot_en_d <= 1'b0;
            pix_on <= 1'b0;
        end else begin
            x <= x_nx;
            mark <= {16'b0, mark_nx};
            slot_en <= en_nx;
            slot_en_d <= slot_en;
            pix_on <= check_in & slot_en_d;
        end
    end
endmodule

// File: tb/tb_num_overlay_ctrl.sv
// tb_num_overlay_ctrl: directed checks of conversion timing, slot scheduling and pixel gating.
module tb_num_overlay_ctrl;
    logic clk = 0, reset = 0, value_valid = 0, frame_start = 0, check_in = 0;
    logic [19:0] value = 0;
    logic [10:0] countx = 0;
    logic [9:0] county = 0;
    logic [19:0] mark;
    logic [10:0] x;
    logic [9:0] y;
    logic pix_on, busy;
    int checks = 0, failures = 0;

    num_overlay_ctrl dut (.clk(clk), .reset(reset), .value(value), .value_valid(value_valid),
        .frame_start(frame_start), .countx(countx), .county(county), .check_in(check_in),
        .mark(mark), .x(x), .y(y), .pix_on(pix_on), .busy(busy));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load(input logic [19:0] v);
        value = v;
        value_valid = 1;
        tick;
        value_valid = 0;
    endtask

    task automatic convert(input int exp_len, input bit inj);
        int n = 0;
        frame_start = 1;
        tick;
        frame_start = 0;
        value_valid = 0;
        for (int k = 0; k < 40; k++) begin
            if (!busy) break;
            n++;
            if (inj && k == 5) begin
                value = 9;
                value_valid = 1;
                frame_start = 1;
            end
            tick;
            value_valid = 0;
            frame_start = 0;
        end
        check("busy_len", n, exp_len);
    endtask

    task automatic show(input string tag, input logic [27:0] exp);
        for (int s = 0; s < 7; s++) begin
            countx = 11'(15 + 20 * s);
            tick;
            check($sformatf("%s_mark%0d", tag, s), mark, {16'b0, exp[4*(6-s) +: 4]});
            check($sformatf("%s_x%0d", tag, s), x, 16 + 20 * s);
        end
    endtask

    task automatic sweep(input string tag, input logic [6:0] en);
        int p;
        logic e;
        check_in = 1;
        for (int c = 0; c <= 200; c++) begin
            countx = 11'(c);
            tick;
            if (c >= 2) begin
                p = c - 1;
                e = 0;
                for (int s = 0; s < 7; s++)
                    if (en[s] && p >= 16 + 20 * s && p <= 35 + 20 * s) e = 1;
                check($sformatf("%s_pix%0d", tag, p), pix_on, e);
            end
        end
    endtask

    initial begin
        countx = 80;
        #12;
        check("rst_mark", mark, 0);
        check("rst_x", x, 0);
        check("rst_pix", pix_on, 0);
        check("rst_busy", busy, 0);
        check("rst_y", y, 16);
        @(negedge clk);
        reset = 1;
        tick;
        convert(0, 0);
        show("idle", 28'h0000000);

        load(20'd1234);
        convert(21, 0);
        show("v1234", 28'h0001234);
        countx = 94; tick;
        check("s3_end_x", x, 76);
        check("s3_end_mark", mark, 1);
        countx = 95; tick;
        check("s4_start_x", x, 96);
        check("s4_start_mark", mark, 2);
        countx = 14; tick;
        check("gap_x", x, 11'h7FF);
        check("gap_mark", mark, 0);
        countx = 200; tick;
        check("right_x", x, 11'h7FF);
`ifdef LEAD_ZERO_BLANK_EN
        sweep("sw1234", 7'b1111000);
`else
        sweep("sw1234", 7'b1111111);
`endif

        load(20'd1048575);
        convert(21, 0);
        show("vmax", 28'h1048575);

        load(20'd5);
        value = 7;
        value_valid = 1;
        convert(21, 1);
        show("bypass", 28'h0000007);
        tick;
        check("pend_wait_busy", busy, 0);
        convert(21, 0);
        show("late9", 28'h0000009);

        load(20'd42);
        convert(21, 0);
        show("v42", 28'h0000042);
`ifdef LEAD_ZERO_BLANK_EN
        sweep("sw42", 7'b1100000);
`else
        sweep("sw42", 7'b1111111);
`endif
        check_in = 0;
        countx = 50;
        tick; tick; tick;
        check("gate_off", pix_on, 0);

        load(20'd0);
        convert(21, 0);
        show("v0", 28'h0000000);
`ifdef LEAD_ZERO_BLANK_EN
        sweep("sw0", 7'b1000000);
`else
        sweep("sw0", 7'b1111111);
`endif

        load(20'd1234);
        frame_start = 1;
        tick;
        frame_start = 0;
        load(20'd55);
        repeat (4) tick;
        check("mid_busy_pre", busy, 1);
        reset = 0;
        #1;
        check("mid_busy", busy, 0);
        check("mid_mark", mark, 0);
        check("mid_x", x, 0);
        check("mid_pix", pix_on, 0);
        @(negedge clk);
        reset = 1;
        tick;
        convert(0, 0);
        show("after_abort", 28'h0000000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
